// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_pkg                                                      |
// | Shared types and constants for the unified-memory arbiter.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mem_arbiter_pkg;

  localparam int c_addr_len      = 32;
  localparam int c_data_len      = 32;
  localparam int c_arb_state_len = 2;

  typedef enum logic [c_arb_state_len-1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // Memory is word addressed on byte addresses: low two bits must be zero
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_if                                                       |
// | Requester ports (instruction, data) and single-port memory bus.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction requester (read only)
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_err;

  // Data requester (read/write)
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_err;

  // Memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              busy;

  // Arbiter view
  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_done, i_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output busy
  );

  // Environment view: CPU requesters plus memory
  modport master (
    output i_req, i_addr,
    input  i_rdata, i_done, i_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter_rr_pick2                                                 |
// | Two-way round-robin picker: on conflict, the port that did not own   |
// | the previous access wins.                                            |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_arbiter_rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last,
  output logic   grant_valid,
  output owner_t grant
);

  // Single requester wins outright; a tie goes to the non-last owner
  always_comb begin
    grant_valid = req_i | req_d;
    grant       = OWNER_I;
    if (req_i && req_d) begin
      grant = (last == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (req_d) begin
      grant = OWNER_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Shares one variable-latency single-port memory between the fetch     |
// | and data requesters; round-robin, misalign and timeout detection.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = c_addr_len,
  parameter int DATA_W  = c_data_len,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  // Timeout of zero disables abort; otherwise abort on the last BUSY cycle
  localparam logic             c_to_en    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  arb_state_t        r_state;
  owner_t            r_last;
  owner_t            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_busy;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_done;
  logic              r_i_err;
  logic              r_d_done;
  logic              r_d_err;

  logic              w_grant_valid;
  owner_t            w_grant;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_req_we;
  logic [DATA_W-1:0] w_req_wdata;
  logic              w_aligned;

  mem_arbiter_rr_pick2 u_pick (
    .req_i       (bus.i_req),
    .req_d       (bus.d_req),
    .last        (r_last),
    .grant_valid (w_grant_valid),
    .grant       (w_grant)
  );

  // Request fields of the granted port; fetches never write
  always_comb begin
    w_req_addr  = bus.i_addr;
    w_req_we    = 1'b0;
    w_req_wdata = '0;
    if (w_grant == OWNER_D) begin
      w_req_addr  = bus.d_addr;
      w_req_we    = bus.d_we;
      w_req_wdata = bus.d_wdata;
    end
    w_aligned = word_aligned(w_req_addr[1:0]);
  end

  // Arbitration FSM; every output is registered so reset clears them at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ARB_IDLE;
      r_last    <= OWNER_D;
      r_owner   <= OWNER_I;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_done  <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses
      r_i_done <= 1'b0;
      r_i_err  <= 1'b0;
      r_d_done <= 1'b0;
      r_d_err  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant;
            r_last  <= w_grant;
            r_addr  <= w_req_addr;
            r_we    <= w_req_we;
            r_wdata <= w_req_wdata;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (!w_aligned) begin
              // Misaligned: fail without touching memory
              r_state <= ARB_RESP;
              if (w_grant == OWNER_I) begin
                r_i_done <= 1'b1;
                r_i_err  <= 1'b1;
              end else begin
                r_d_done <= 1'b1;
                r_d_err  <= 1'b1;
              end
            end else begin
              r_state   <= ARB_BUSY;
              r_mem_req <= 1'b1;
              r_mem_we  <= w_req_we;
            end
          end
        end
        ARB_BUSY: begin
          if (bus.mem_ack) begin
            // Ack takes priority over a coincident timeout
            r_state   <= ARB_RESP;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_owner == OWNER_I) begin
              r_i_done  <= 1'b1;
              r_i_rdata <= bus.mem_rdata;
            end else begin
              r_d_done <= 1'b1;
              if (!r_we) begin
                r_d_rdata <= bus.mem_rdata;
              end
            end
          end else if (c_to_en && (r_cnt == c_cnt_last)) begin
            r_state   <= ARB_RESP;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_owner == OWNER_I) begin
              r_i_done <= 1'b1;
              r_i_err  <= 1'b1;
            end else begin
              r_d_done <= 1'b1;
              r_d_err  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ARB_RESP: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ARB_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy      = r_busy;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_done    = r_i_done;
  assign bus.i_err     = r_i_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_err     = r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Directed self-checking bench for mem_arbiter (TIMEOUT = 4).          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic clk;
  logic rst;

  int n_err;
  int n_chk;

  // Observations collected by run_access
  int          lat;
  int          nreq;
  int          nwe;
  logic        got_i;
  logic        got_d;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;

  // Expected rdata model: updates only on successful reads
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step cycle by cycle acting as memory: ack on the (waits+1)-th BUSY cycle,
  // never when waits < 0. Returns at the negedge where a done pulse is seen.
  task automatic run_access(input int waits, input logic [31:0] rd, input int max_cyc);
    lat = 0; nreq = 0; nwe = 0; got_i = 1'b0; got_d = 1'b0;
    seen_addr = '0; seen_wdata = '0;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        nreq++;
        if (bus.mem_we) nwe++;
        seen_addr     = bus.mem_addr;
        seen_wdata    = bus.mem_wdata;
        bus.mem_ack   = (waits >= 0) && (nreq == waits + 1);
        bus.mem_rdata = rd;
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (bus.i_done || bus.d_done) begin
        lat   = k;
        got_i = bus.i_done;
        got_d = bus.d_done;
        bus.mem_ack = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.mem_ack = 1'b0;
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_err = 0; n_chk = 0;
    rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    exp_i_rdata = '0; exp_d_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we",  {31'd0, bus.mem_we},  32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_busy",    {31'd0, bus.busy},    32'd0);
    check("rst_done_err", {28'd0, bus.i_done, bus.i_err, bus.d_done, bus.d_err}, 32'd0);
    check("rst_rdata",   bus.i_rdata | bus.d_rdata, 32'd0);

    // Conflict in first cycle: instruction wins (last owner = D), zero-wait read
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200;
    run_access(0, 32'h8C01_0004, 20);
    exp_i_rdata = 32'h8C01_0004;
    check("zw_grant_i", {31'd0, got_i}, 32'd1);
    check("zw_no_d",    {31'd0, got_d}, 32'd0);
    check("zw_latency", lat, 2);
    check("zw_nreq",    nreq, 1);
    check("zw_addr",    seen_addr, 32'h0000_0040);
    check("zw_rdata",   bus.i_rdata, exp_i_rdata);
    check("zw_err",     {31'd0, bus.i_err}, 32'd0);
    check("zw_busy",    {31'd0, bus.busy}, 32'd1);

    // Data port, still requesting, is served next
    bus.i_req = 1'b0;
    run_access(0, 32'h1111_2222, 20);
    exp_d_rdata = 32'h1111_2222;
    check("cf_grant_d", {31'd0, got_d}, 32'd1);
    check("cf_latency", lat, 3);
    check("cf_addr",    seen_addr, 32'h0000_0200);
    check("cf_d_rdata", bus.d_rdata, exp_d_rdata);
    check("cf_i_hold",  bus.i_rdata, exp_i_rdata);

    // Persistent conflict alternates I, D, I, D
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0044;
    for (int a = 0; a < 4; a++) begin
      run_access(0, 32'hA000_0001 + a, 20);
      check("alt_grant_i", {31'd0, got_i}, {31'd0, (a % 2) == 0});
      check("alt_latency", lat, 3);
      if (got_i) exp_i_rdata = 32'hA000_0001 + a;
      if (got_d) exp_d_rdata = 32'hA000_0001 + a;
    end
    check("alt_i_rdata", bus.i_rdata, exp_i_rdata);
    check("alt_d_rdata", bus.d_rdata, exp_d_rdata);
    idle(1);

    // Write with 3 wait states; ack coincides with the timeout point
    bus.d_req = 1'b1; bus.d_we = 1'b1;
    bus.d_addr = 32'h0000_0100; bus.d_wdata = 32'hDEAD_BEEF;
    run_access(3, 32'hFFFF_FFFF, 20);
    check("wr_grant_d", {31'd0, got_d}, 32'd1);
    check("wr_latency", lat, 5);
    check("wr_nwe",     nwe, 4);
    check("wr_addr",    seen_addr, 32'h0000_0100);
    check("wr_wdata",   seen_wdata, 32'hDEAD_BEEF);
    check("wr_err",     {31'd0, bus.d_err}, 32'd0);
    check("wr_d_hold",  bus.d_rdata, exp_d_rdata);
    idle(1);

    // Misaligned data read: no memory access, error in the next cycle
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0102;
    run_access(0, 32'h5555_5555, 20);
    check("mis_grant_d", {31'd0, got_d}, 32'd1);
    check("mis_latency", lat, 1);
    check("mis_nreq",    nreq, 0);
    check("mis_err",     {31'd0, bus.d_err}, 32'd1);
    check("mis_d_hold",  bus.d_rdata, exp_d_rdata);
    idle(1);

    // Timeout: no ack ever, 4 BUSY cycles then error
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080;
    run_access(-1, 32'h7777_7777, 20);
    check("to_grant_i", {31'd0, got_i}, 32'd1);
    check("to_nreq",    nreq, 4);
    check("to_latency", lat, 5);
    check("to_err",     {31'd0, bus.i_err}, 32'd1);
    check("to_i_hold",  bus.i_rdata, exp_i_rdata);
    idle(1);

    // Reset during BUSY: outputs clear immediately, no completion
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0048;
    @(negedge clk);
    check("rm_in_busy", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("rm_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rm_busy",    {31'd0, bus.busy}, 32'd0);
    check("rm_rdata",   bus.i_rdata, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rm_no_done", {30'd0, bus.i_done, bus.d_done}, 32'd0);
    end
    exp_i_rdata = '0; exp_d_rdata = '0;
    rst = 1'b1;
    run_access(0, 32'h1234_5678, 20);
    exp_i_rdata = 32'h1234_5678;
    check("rm_reissue", {31'd0, got_i}, 32'd1);
    check("rm_latency", lat, 2);
    check("rm_addr",    seen_addr, 32'h0000_0048);
    check("rm_i_rdata", bus.i_rdata, exp_i_rdata);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified, variable-latency memory between the instruction-fetch requester (read-only) and the data requester (read/write) of the multi-period CPU.
- Sits between the CPU's IF/MEM state logic and a single-port memory with a req/ack handshake.
- Arbitrates round-robin and detects misaligned and timed-out accesses.
- Returns read data and a one-cycle completion pulse per access.

Parameters:
- ADDR_W, 32 (`ADDR_LEN`): address width.
- DATA_W, 32 (`DATA_LEN`): data width.
- TIMEOUT, 16: cycles in BUSY without mem_ack before abort. 0 disables the timeout.
- CNT_W, 8: timeout counter width. Requires TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction requester wants a read.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched word.
- i_done  out  1  one-cycle completion pulse for the instruction port.
- i_err  out  1  valid with i_done: access failed.
- d_req  in  1  data requester wants an access.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read word.
- d_done  out  1  one-cycle completion pulse for the data port.
- d_err  out  1  valid with d_done: access failed.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid while mem_ack = 1.
- mem_ack  in  1  memory completes the access this cycle.
- busy  out  1  high in BUSY and RESP.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE and last_owner = D.
  - All outputs go to 0 immediately, including mem_req, mem_we, mem_addr, mem_wdata, both rdata, both done, both err, and busy.
  - An access aborted by reset is never completed. The requester re-issues it after reset.
- Requester rule: hold req, addr, we and wdata stable until the matching done. Deassert req, or present a new request, in the cycle after done.
- State encodings: IDLE, BUSY, RESP, held in a 2-bit register.
- IDLE:
  - Sample i_req and d_req.
  - Exactly one request high: grant that port.
  - Both high: grant the port that is not last_owner.
  - On grant, latch owner, address, we and wdata; set last_owner = owner. The instruction port always latches we = 0.
  - Granted addr[1:0] != 0: go to RESP with err = 1. No memory access is made.
  - Otherwise go to BUSY and clear the timeout counter.
- BUSY:
  - mem_req = 1 and mem_we/mem_addr/mem_wdata are driven from the latched values.
  - On mem_ack = 1: capture mem_rdata if this is a read; go to RESP with err = 0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT - 1 without ack: go to RESP with err = 1 and leave the owner's rdata unchanged.
  - mem_ack wins over timeout if both occur in the same cycle.
- RESP:
  - Owner's done = 1 for exactly one cycle. Owner's err is valid in that cycle.
  - mem_req = 0. Requests are not sampled. Next state is IDLE.
- rdata behaviour:
  - i_rdata/d_rdata are registered and update only on a successful read completion for that port; otherwise they hold.
  - Writes leave d_rdata unchanged.
- mem_ack is ignored outside BUSY.
- Latency with a zero-wait memory: request sampled at edge N, mem_req high in cycle N+1, done in cycle N+2. The minimum interval between accesses is 3 cycles. Each wait cycle adds 1.
- A request with no ack at all completes with err in cycle N+1+TIMEOUT, i.e. after TIMEOUT cycles in BUSY.

Decomposition:
- Shared defines.v additions: `ARB_STATE_LEN`, `ARB_IDLE`/`ARB_BUSY`/`ARB_RESP`, `OWNER_I`/`OWNER_D`.
- One natural sub-module: rr_pick2, a combinational two-way round-robin picker with inputs req_i, req_d, last and outputs grant_valid, grant.
- The timeout counter stays inline.

Test Plan:
- Zero-wait read: i_req = 1, i_addr = 0x00000040, mem_ack tied 1, mem_rdata = 0x8C010004 -> mem_req high for 1 cycle with mem_addr = 0x40; i_done 2 cycles after sampling; i_rdata = 0x8C010004; i_err = 0.
- Conflict after reset: i_req and d_req both 1 in the first cycle -> instruction granted first, then data. Repeat the conflict -> grants alternate I, D, I, D.
- Data write with 3 wait states: d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF, mem_ack after 3 cycles -> mem_we = 1 for 4 cycles; d_done 1 cycle later; d_rdata unchanged; d_err = 0.
- Misaligned: d_addr = 0x102 -> no mem_req; d_done and d_err in the cycle after sampling.
- Timeout: TIMEOUT = 4, mem_ack held 0 -> mem_req high exactly 4 cycles; then i_done = 1, i_err = 1; i_rdata keeps its previous value.
- Reset mid-access: rst = 0 during BUSY -> mem_req = 0 immediately, no done pulse; after reset, re-issuing the same request completes normally.
